frontend_mt: RTL and testbench

Parametrised second-generation TPU front end. It sits between the MPU-side instruction allocator and a TPU's instruction buffer. Each request carries a header of two words (issue number, then thread ID), followed by an instruction stream. The block parses the header, queues instructions in an internal FIFO so a full back end never drops a word, drains the FIFO on termination, and reports aborts, overflows and back-end NACKs to the allocator.

---
 rtl/pkg_tpu.sv | 12 +
 rtl/tpu_fe_fifo.sv | 61 ++++++
 rtl/frontend_mt.sv | 127 ++++++++++++
 tb/tb_frontend_mt.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_tpu.sv
// Shared types for the second-generation TPU front end.
package pkg_tpu;

    typedef enum logic [2:0] {
        FE_IDLE   = 3'd0,
        FE_ISSUE  = 3'd1,
        FE_THREAD = 3'd2,
        FE_INSTR  = 3'd3,
        FE_DRAIN  = 3'd4
    } fsm_tpu_fe_mt_t;

endpackage

// File: rtl/tpu_fe_fifo.sv
// Synchronous FIFO with registered read data; flush empties it in one cycle.
module tpu_fe_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            rdata <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) begin
                rptr  <= rptr + 1'b1;
                rdata <= mem[rptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clock) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/frontend_mt.sv
// TPU front end: parses the issue/thread header, buffers the instruction
// stream in a FIFO and drains it to the back-end instruction buffer.
module frontend_mt
    import pkg_tpu::*;
#(
    parameter int INSTR_W = 64,
    parameter int ISSUE_W = 8,
    parameter int TID_W   = 8,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               I_En_Exe,
    input  logic               I_Req,
    input  logic               I_Instr_V,
    input  logic [INSTR_W-1:0] I_Instr,
    input  logic               I_Term,
    input  logic               I_Full,
    input  logic               I_Nack,
    output logic               O_Ready,
    output logic               O_We,
    output logic [INSTR_W-1:0] O_Instr,
    output logic [TID_W-1:0]   O_ThreadID,
    output logic [ISSUE_W-1:0] O_IssueNo,
    output logic [CNT_W-1:0]   O_Count,
    output logic               O_Term,
    output logic               O_Nack,
    output logic               O_Busy
);

    localparam int AW = $clog2(DEPTH);

    fsm_tpu_fe_mt_t state;
    fsm_tpu_fe_mt_t state_nxt;

    logic          fifo_full;
    logic          fifo_empty;
    logic [AW:0]   fifo_count;
    logic          in_stream;
    logic          abort;
    logic          accept;
    logic          push;
    logic          pop;
    logic          overflow;
    logic          drain_done;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        in_stream = (state == FE_INSTR) || (state == FE_DRAIN);
        abort     = (state != FE_IDLE) && !I_Req;
        case (state)
            FE_ISSUE, FE_THREAD: O_Ready = 1'b1;
            FE_INSTR:            O_Ready = !fifo_full;
            default:             O_Ready = 1'b0;
        endcase
        accept     = I_Instr_V && O_Ready && !abort;
        push       = accept && (state == FE_INSTR);
        pop        = in_stream && !fifo_empty && !I_Full && I_En_Exe && !abort;
        overflow   = I_Instr_V && !O_Ready && in_stream;
        // Wait for the final strobe to retire before reporting completion.
        drain_done = (state == FE_DRAIN) && (fifo_count == '0) && !O_We && I_Req;
        O_Term     = drain_done;
        O_Busy     = (state != FE_IDLE);
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = FE_IDLE;
        end else begin
            case (state)
                FE_IDLE:   if (I_Req)      state_nxt = FE_ISSUE;
                FE_ISSUE:  if (accept)     state_nxt = FE_THREAD;
                FE_THREAD: if (accept)     state_nxt = FE_INSTR;
                FE_INSTR:  if (I_Term)     state_nxt = FE_DRAIN;
                FE_DRAIN:  if (drain_done) state_nxt = FE_IDLE;
                default:                   state_nxt = FE_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= FE_IDLE;
            O_We       <= 1'b0;
            O_Nack     <= 1'b0;
            O_IssueNo  <= '0;
            O_ThreadID <= '0;
            O_Count    <= '0;
        end else begin
            state  <= state_nxt;
            O_We   <= pop;
            O_Nack <= I_Nack || abort || overflow;
            if (abort || drain_done) begin
                O_IssueNo  <= '0;
                O_ThreadID <= '0;
            end else begin
                if (accept && state == FE_ISSUE)  O_IssueNo  <= I_Instr[ISSUE_W-1:0];
                if (accept && state == FE_THREAD) O_ThreadID <= I_Instr[TID_W-1:0];
            end
            if (accept && state == FE_ISSUE) O_Count <= '0;
            else if (pop)                    O_Count <= sat_inc(O_Count);
        end
    end

    // Read data is registered inside the FIFO, so it lines up with O_We.
    tpu_fe_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (abort),
        .wdata (I_Instr),
        .rdata (O_Instr),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_frontend_mt.sv
// Bench for frontend_mt: transaction-level model plus output scoreboard.
module tb_frontend_mt;

    localparam int DEPTH = 8;
    localparam int PH_IDLE = 0, PH_ISSUE = 1, PH_THREAD = 2, PH_INSTR = 3, PH_DRAIN = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        I_En_Exe = 1'b0, I_Req = 1'b0, I_Instr_V = 1'b0, I_Term = 1'b0;
    logic        I_Full = 1'b0, I_Nack = 1'b0;
    logic [63:0] I_Instr = '0;
    logic        O_Ready, O_We, O_Term, O_Nack, O_Busy;
    logic [63:0] O_Instr;
    logic [7:0]  O_ThreadID, O_IssueNo;
    logic [15:0] O_Count;

    frontend_mt #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .I_En_Exe(I_En_Exe), .I_Req(I_Req),
        .I_Instr_V(I_Instr_V), .I_Instr(I_Instr), .I_Term(I_Term), .I_Full(I_Full),
        .I_Nack(I_Nack), .O_Ready(O_Ready), .O_We(O_We), .O_Instr(O_Instr),
        .O_ThreadID(O_ThreadID), .O_IssueNo(O_IssueNo), .O_Count(O_Count),
        .O_Term(O_Term), .O_Nack(O_Nack), .O_Busy(O_Busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: protocol phase, words held by the front end, emitted count.
    int          phase = PH_IDLE;
    int          mcount = 0;
    int          mcnt = 0;
    bit          mpop_last = 1'b0;
    logic [7:0]  exp_issue = '0;
    logic [7:0]  exp_tid = '0;
    logic [63:0] exp_q[$];
    bit          exp_nack[int];
    logic [63:0] w_exp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit chance(input int pct);
        return $urandom_range(99, 0) < pct;
    endfunction

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    // One clocked cycle with I_Req held high; checks outputs against the model.
    task automatic drive_cycle(input bit v, input logic [63:0] w, input bit term,
                               input bit full, input bit en, input bit nack, output bit acc);
        bit rdy, pop, exp_term, stream;
        I_Req = 1'b1; I_Instr_V = v; I_Instr = w; I_Term = term;
        I_Full = full; I_En_Exe = en; I_Nack = nack;
        #1;
        stream   = (phase == PH_INSTR) || (phase == PH_DRAIN);
        rdy      = (phase == PH_ISSUE) || (phase == PH_THREAD) ||
                   (phase == PH_INSTR && mcount < DEPTH);
        exp_term = (phase == PH_DRAIN) && (mcount == 0) && !mpop_last;
        chk("ready", O_Ready, rdy);
        chk("we_strobe", O_We, mpop_last);
        chk("term_pulse", O_Term, exp_term);
        chk("busy", O_Busy, phase != PH_IDLE);
        chk("issue_no", O_IssueNo, exp_issue);
        chk("thread_id", O_ThreadID, exp_tid);
        chk("count", O_Count, mcnt);
        acc = v && rdy;
        pop = stream && (mcount > 0) && !full && en;
        if (nack || (v && !rdy && stream)) exp_nack[cyc + 1] = 1'b1;
        case (phase)
            PH_IDLE:   phase = PH_ISSUE;
            PH_ISSUE:  if (acc) begin exp_issue = w[7:0]; mcnt = 0; phase = PH_THREAD; end
            PH_THREAD: if (acc) begin exp_tid = w[7:0]; phase = PH_INSTR; end
            PH_INSTR: begin
                if (acc) begin exp_q.push_back(w); mcount++; end
                if (term) phase = PH_DRAIN;
            end
            PH_DRAIN:  if (exp_term) begin phase = PH_IDLE; exp_issue = '0; exp_tid = '0; end
            default:   phase = PH_IDLE;
        endcase
        if (pop) begin
            mcount--;
            if (mcnt < 65535) mcnt++;
        end
        mpop_last = pop;
        @(posedge clock); #1;
    endtask

    task automatic idle_cycle(input bit nack);
        I_Req = 1'b0; I_Instr_V = 1'b0; I_Term = 1'b0; I_Full = 1'b0; I_En_Exe = 1'b0;
        I_Nack = nack;
        #1;
        chk("idle_ready", O_Ready, 1'b0);
        chk("idle_busy", O_Busy, phase != PH_IDLE);
        chk("idle_we", O_We, mpop_last);
        chk("idle_term", O_Term, 1'b0);
        chk("idle_issue_no", O_IssueNo, exp_issue);
        chk("idle_count", O_Count, mcnt);
        if (nack) exp_nack[cyc + 1] = 1'b1;
        mpop_last = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic abort_cycle();
        I_Req = 1'b0; I_Instr_V = 1'b1; I_Instr = r64(); I_Term = 1'b1;
        I_Full = 1'b0; I_En_Exe = 1'b1; I_Nack = 1'b0;
        #1;
        chk("abort_we", O_We, mpop_last);
        chk("abort_term", O_Term, 1'b0);
        if (phase != PH_IDLE) exp_nack[cyc + 1] = 1'b1;
        @(posedge clock); #1;
        exp_q.delete();
        mcount = 0; mpop_last = 1'b0; phase = PH_IDLE;
        exp_issue = '0; exp_tid = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        I_Req = 1'b0; I_Instr_V = 1'b0; I_Term = 1'b0; I_Full = 1'b0; I_En_Exe = 1'b0; I_Nack = 1'b0;
        #1;
        chk("rst_ready", O_Ready, 1'b0);
        chk("rst_we", O_We, 1'b0);
        chk("rst_instr", O_Instr, 64'h0);
        chk("rst_thread_id", O_ThreadID, 8'h0);
        chk("rst_issue_no", O_IssueNo, 8'h0);
        chk("rst_count", O_Count, 16'h0);
        chk("rst_term", O_Term, 1'b0);
        chk("rst_nack", O_Nack, 1'b0);
        chk("rst_busy", O_Busy, 1'b0);
        exp_q.delete(); exp_nack.delete();
        phase = PH_IDLE; mcount = 0; mcnt = 0; mpop_last = 1'b0; exp_issue = '0; exp_tid = '0;
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic start_txn(input logic [7:0] issue, input logic [7:0] tid, input int pn);
        logic [63:0] w;
        bit a;
        drive_cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, chance(pn), a);
        w = r64(); w[7:0] = issue;
        drive_cycle(1'b1, w, 1'b0, 1'b0, 1'b1, chance(pn), a);
        w = r64(); w[7:0] = tid;
        drive_cycle(1'b1, w, 1'b0, 1'b0, 1'b1, chance(pn), a);
    endtask

    // Sends n instruction words then Term; returns early (aborted=1) on a random abort.
    task automatic send_words(input int n, input int pv, input int pf, input int pe, input int pn,
                              input bit term_last, input int pabort, output bit aborted);
        int  got = 0;
        int  guard = 0;
        bit  a, v, t;
        aborted = 1'b0;
        t = 1'b0;
        while (got < n && guard < 1000) begin
            if (pabort > 0 && chance(pabort)) begin
                abort_cycle();
                aborted = 1'b1;
                return;
            end
            v = chance(pv);
            t = term_last && v && (got == n - 1);
            drive_cycle(v, r64(), t, chance(pf), chance(pe), chance(pn), a);
            if (a) got++;
            if (t) break;
            guard++;
        end
        if (!t) drive_cycle(1'b0, 64'h0, 1'b1, chance(pf), chance(pe), chance(pn), a);
    endtask

    task automatic finish_txn(input int pf, input int pe, input int pn);
        int guard = 0;
        bit a;
        while (phase != PH_IDLE && guard < 400) begin
            drive_cycle(1'b0, 64'h0, 1'b0, chance(pf), chance(pe), chance(pn), a);
            guard++;
        end
        if (phase != PH_IDLE) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: transaction still open after %0d cycles", guard);
        end
    endtask

    // Scoreboard monitor: every write strobe must carry the oldest outstanding word.
    always @(negedge clock) begin
        if (reset) begin
            if (O_We) begin
                chk("we_has_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    w_exp = exp_q.pop_front();
                    chk("instr_order", O_Instr, w_exp);
                end
            end
            chk("nack_out", O_Nack, exp_nack.exists(cyc));
            if (O_Term) chk("term_after_last_we", exp_q.size(), 0);
        end
    end

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a, ab;
        #1;
        do_reset();
        idle_cycle(1'b0);

        // Nominal: issue 5, thread 3, four instructions, then Term.
        start_txn(8'h05, 8'h03, 0);
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, r64(), 1'b0, 1'b0, 1'b1, 1'b0, a);
        drive_cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0, a);
        finish_txn(0, 100, 0);
        chk("nominal_count", O_Count, 16'd4);
        idle_cycle(1'b0);

        // Back-pressure: fill all eight slots, overflow once, then release.
        start_txn(8'h21, 8'h42, 0);
        for (int i = 0; i < 9; i++) drive_cycle(1'b1, r64(), 1'b0, 1'b1, 1'b1, 1'b0, a);
        for (int i = 0; i < 8; i++) drive_cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, a);
        drive_cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0, a);
        finish_txn(0, 100, 0);
        idle_cycle(1'b0);

        // Abort with three words queued.
        start_txn(8'h77, 8'h11, 0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, r64(), 1'b0, 1'b1, 1'b1, 1'b0, a);
        abort_cycle();
        for (int i = 0; i < 3; i++) idle_cycle(1'b0);

        // Push and pop together at four entries, then Term with the final word.
        start_txn(8'h3c, 8'hc3, 0);
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, r64(), 1'b0, 1'b1, 1'b1, 1'b0, a);
        drive_cycle(1'b1, r64(), 1'b0, 1'b0, 1'b1, 1'b0, a);
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, r64(), 1'b0, 1'b1, 1'b1, 1'b0, a);
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, a);
        drive_cycle(1'b1, r64(), 1'b1, 1'b0, 1'b1, 1'b0, a);
        finish_txn(0, 100, 0);
        idle_cycle(1'b0);

        // Reset while draining, then a clean transaction.
        start_txn(8'h99, 8'h66, 0);
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, r64(), 1'b0, 1'b1, 1'b1, 1'b0, a);
        drive_cycle(1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 1'b0, a);
        drive_cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, a);
        drive_cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, a);
        do_reset();
        start_txn(8'h12, 8'h34, 0);
        send_words(3, 100, 0, 100, 0, 1'b1, 0, ab);
        finish_txn(0, 100, 0);

        // NACK passthrough from the back end.
        idle_cycle(1'b1);
        idle_cycle(1'b0);
        idle_cycle(1'b1);
        idle_cycle(1'b1);
        idle_cycle(1'b0);

        // Random back-to-back transactions.
        for (int t = 0; t < 30; t++) begin
            start_txn(8'($urandom), 8'($urandom), 5);
            send_words($urandom_range(14, 0), $urandom_range(100, 40), $urandom_range(70, 0),
                       $urandom_range(100, 30), 5, bit'($urandom_range(1, 0)), 3, ab);
            if (!ab) finish_txn($urandom_range(60, 0), $urandom_range(100, 40), 5);
            for (int g = 0; g < int'($urandom_range(2, 0)); g++) idle_cycle(chance(10));
        end
        idle_cycle(1'b0);
        idle_cycle(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
